// File: rtl/char_overlay_pkg.sv
// Shared widths, pixel side-band record and glyph helper for the char_overlay text overlay.
package char_overlay_pkg;

    localparam int GLYPH_W   = 16;
    localparam int GLYPH_H   = 16;
    localparam int CODE_W    = 9;
    localparam int COORD_W   = 11;
    localparam int ROM_AW    = 13;
    localparam int ROM_DW    = 16;
    localparam int TXT_DEPTH = 128;
    localparam int TXT_AW    = 7;

    typedef logic [15:0] rgb565_t;

    typedef struct packed {
        logic    de;
        logic    hs;
        logic    vs;
        logic    in_box;
        logic [3:0] gx;
        rgb565_t rgb;
    } pix_side_t;

    // Bit 15 of a glyph row is the leftmost pixel, so column gx maps to bit 15-gx.
    function automatic logic glyph_bit(input logic [ROM_DW-1:0] row, input logic [3:0] gx);
        return row[4'(ROM_DW-1) - gx];
    endfunction

endpackage

// File: rtl/char_overlay_txtbuf.sv
// char_overlay_txtbuf: 128x9 character-code register file, synchronous write and clear,
// asynchronous read so a same-cycle write is only visible on the following cycle.
module char_overlay_txtbuf
    import char_overlay_pkg::*;
#(
    parameter int DEPTH = TXT_DEPTH
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [TXT_AW-1:0] i_waddr,
    input  logic [CODE_W-1:0] i_wdata,
    input  logic [TXT_AW-1:0] i_raddr,
    output logic [CODE_W-1:0] o_rdata
);

    logic [CODE_W-1:0] r_mem [TXT_DEPTH];

    // Cells beyond the configured box are never displayed, so writes to them are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TXT_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (int'(i_waddr) < DEPTH)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/char_overlay.sv
// char_overlay: text-box overlay on an RGB565 pixel stream using an external glyph ROM.
// Build option: define CHAR_OVERLAY_BG_EN for an opaque box painted with BG_COLOR.
module char_overlay
    import char_overlay_pkg::*;
#(
    parameter int      TEXT_X0  = 16,
    parameter int      TEXT_Y0  = 16,
    parameter int      COLS     = 32,
    parameter int      ROWS     = 4,
    parameter rgb565_t FG_COLOR = 16'hFFFF,
    parameter rgb565_t BG_COLOR = 16'h0000
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_de,
    input  logic               in_hs,
    input  logic               in_vs,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  rgb565_t            in_rgb,
    input  logic               txt_we,
    input  logic [TXT_AW-1:0]  txt_waddr,
    input  logic [CODE_W-1:0]  txt_wdata,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [ROM_DW-1:0]  rom_data,
    output logic               out_de,
    output logic               out_hs,
    output logic               out_vs,
    output rgb565_t            out_rgb
);

`ifdef CHAR_OVERLAY_BG_EN
    localparam bit BG_EN = 1'b1;
`else
    localparam bit BG_EN = 1'b0;
`endif

    localparam int X_END = TEXT_X0 + GLYPH_W * COLS;
    localparam int Y_END = TEXT_Y0 + GLYPH_H * ROWS;
    localparam int CELLS = COLS * ROWS;

    logic               r_inDe;
    logic               r_inHs;
    logic               r_inVs;
    logic [COORD_W-1:0] r_inX;
    logic [COORD_W-1:0] r_inY;
    rgb565_t            r_inRgb;

    logic [COORD_W-1:0] w_offX;
    logic [COORD_W-1:0] w_offY;
    logic               w_inBox;
    logic [TXT_AW-1:0]  w_cell;
    pix_side_t          w_s1Next;

    pix_side_t          r_s1Side;
    logic [TXT_AW-1:0]  r_s1Cell;
    logic [3:0]         r_s1Gy;

    logic [CODE_W-1:0]  w_code;
    pix_side_t          r_s2Side;
    logic [ROM_AW-1:0]  r_romAddr;

    pix_side_t          r_s3Side;
    logic               w_glyphBit;
    rgb565_t            w_outRgb;

    logic               r_outDe;
    logic               r_outHs;
    logic               r_outVs;
    rgb565_t            r_outRgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inDe  <= 1'b0;
            r_inHs  <= 1'b0;
            r_inVs  <= 1'b0;
            r_inX   <= '0;
            r_inY   <= '0;
            r_inRgb <= '0;
        end else begin
            r_inDe  <= in_de;
            r_inHs  <= in_hs;
            r_inVs  <= in_vs;
            r_inX   <= in_x;
            r_inY   <= in_y;
            r_inRgb <= in_rgb;
        end
    end

    // Range checks happen on the raw coordinates, so offsets below the box origin never wrap in.
    assign w_offX  = r_inX - COORD_W'(TEXT_X0);
    assign w_offY  = r_inY - COORD_W'(TEXT_Y0);
    assign w_inBox = r_inDe
                     && (int'(r_inX) >= TEXT_X0) && (int'(r_inX) < X_END)
                     && (int'(r_inY) >= TEXT_Y0) && (int'(r_inY) < Y_END);
    assign w_cell  = w_offY[COORD_W-1:4] * TXT_AW'(COLS) + w_offX[COORD_W-1:4];

    assign w_s1Next = '{de: r_inDe, hs: r_inHs, vs: r_inVs, in_box: w_inBox,
                        gx: w_offX[3:0], rgb: r_inRgb};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Side <= '0;
            r_s1Cell <= '0;
            r_s1Gy   <= '0;
        end else begin
            r_s1Side <= w_s1Next;
            r_s1Cell <= w_cell;
            r_s1Gy   <= w_offY[3:0];
        end
    end

    char_overlay_txtbuf #(
        .DEPTH (CELLS)
    ) u_txtbuf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (txt_we),
        .i_waddr (txt_waddr),
        .i_wdata (txt_wdata),
        .i_raddr (r_s1Cell),
        .o_rdata (w_code)
    );

    // Out-of-box pixels leave the ROM address alone; their glyph data is ignored downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Side  <= '0;
            r_romAddr <= '0;
            r_s3Side  <= '0;
        end else begin
            r_s2Side <= r_s1Side;
            r_s3Side <= r_s2Side;
            if (r_s1Side.in_box) begin
                r_romAddr <= {w_code, r_s1Gy};
            end
        end
    end

    assign rom_addr   = r_romAddr;
    assign w_glyphBit = glyph_bit(rom_data, r_s3Side.gx);

    always_comb begin
        w_outRgb = r_s3Side.rgb;
        if (!r_s3Side.de) begin
            w_outRgb = '0;
        end else if (r_s3Side.in_box && w_glyphBit) begin
            w_outRgb = FG_COLOR;
        end else if (r_s3Side.in_box && BG_EN) begin
            w_outRgb = BG_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outDe  <= 1'b0;
            r_outHs  <= 1'b0;
            r_outVs  <= 1'b0;
            r_outRgb <= '0;
        end else begin
            r_outDe  <= r_s3Side.de;
            r_outHs  <= r_s3Side.hs;
            r_outVs  <= r_s3Side.vs;
            r_outRgb <= w_outRgb;
        end
    end

    assign out_de  = r_outDe;
    assign out_hs  = r_outHs;
    assign out_vs  = r_outVs;
    assign out_rgb = r_outRgb;

endmodule

// File: tb/tb_char_overlay.sv
// Bench for char_overlay: directed vector table, hand-written corner sequences and a randomized
// stream compared every cycle against a behavioural model of the text overlay.
`timescale 1ns/1ps
module tb_char_overlay;
    import char_overlay_pkg::*;

    localparam int X0    = 16;
    localparam int Y0    = 16;
    localparam int NCOLS = 32;
    localparam int NROWS = 4;
    localparam logic [15:0] FG = 16'hFFFF;
    localparam logic [15:0] BG = 16'h0841;
    localparam int MAXC = 4096;
`ifdef CHAR_OVERLAY_BG_EN
    localparam bit BG_EN = 1'b1;
`else
    localparam bit BG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
    logic [10:0] in_x = '0, in_y = '0;
    logic [15:0] in_rgb = '0;
    logic        txt_we = 1'b0;
    logic [6:0]  txt_waddr = '0;
    logic [8:0]  txt_wdata = '0;
    logic [12:0] rom_addr;
    logic [15:0] rom_data;
    logic        out_de, out_hs, out_vs;
    logic [15:0] out_rgb;

    logic [15:0] romMem [8192];
    logic [8:0]  textRef [128];

    bit          hDe [MAXC];
    bit          hHs [MAXC];
    bit          hVs [MAXC];
    bit          hRst [MAXC];
    bit          hInBox [MAXC];
    logic [15:0] hRgb [MAXC];
    int          hCell [MAXC];
    int          hGx [MAXC];
    int          hGy [MAXC];
    logic [15:0] eRgb [MAXC];
    logic [12:0] eAddr [MAXC];
    logic [12:0] mAddr = '0;
    int          cyc = 0;

    int passCount = 0;
    int checkCount = 0;

    typedef struct {
        int          x;
        int          y;
        logic        de;
        logic [15:0] rgb;
        logic        chkAddr;
        logic [12:0] addr;
        logic [15:0] romWord;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [10];

    char_overlay #(
        .TEXT_X0  (X0),
        .TEXT_Y0  (Y0),
        .COLS     (NCOLS),
        .ROWS     (NROWS),
        .FG_COLOR (FG),
        .BG_COLOR (BG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_de     (in_de),
        .in_hs     (in_hs),
        .in_vs     (in_vs),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_rgb    (in_rgb),
        .txt_we    (txt_we),
        .txt_waddr (txt_waddr),
        .txt_wdata (txt_wdata),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .out_de    (out_de),
        .out_hs    (out_hs),
        .out_vs    (out_vs),
        .out_rgb   (out_rgb)
    );

    always #5 clk = ~clk;

    // External glyph ROM: registered address, data valid in the cycle after the sampling edge.
    always @(posedge clk) rom_data <= romMem[rom_addr];

    function automatic logic [15:0] glyphZero(input logic [15:0] rgb);
        return BG_EN ? BG : rgb;
    endfunction

    function automatic bit rstWithin(input int lo, input int hi);
        for (int i = (lo < 0 ? 0 : lo); i <= hi; i++) begin
            if (hRst[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference: what pixel k must look like, using the text contents as of its buffer read.
    task automatic computeExpect(input int k);
        int a;
        logic [15:0] word;
        if (hInBox[k]) begin
            a = int'(textRef[hCell[k]]) * 16 + hGy[k];
            word = romMem[a];
            eAddr[k] = 13'(a);
            eRgb[k] = word[15 - hGx[k]] ? FG : glyphZero(hRgb[k]);
        end else begin
            eAddr[k] = '0;
            eRgb[k] = hDe[k] ? hRgb[k] : 16'h0000;
        end
    endtask

    task automatic checkOutput(input int c);
        int k;
        bit have;
        logic [18:0] expV;
        k = c - 4;
        have = 1'b1;
        expV = '0;
        if (rstWithin(k, c)) expV = '0;
        else if (k < 0) have = 1'b0;
        else expV = {hDe[k], hHs[k], hVs[k], eRgb[k]};
        if (have) compare("pipe_de_hs_vs_rgb", 32'({out_de, out_hs, out_vs, out_rgb}), 32'(expV));
        compare("rom_addr_model", 32'(rom_addr), 32'(mAddr));
    endtask

    task automatic applyStimulus(input logic de, input logic hs, input logic vs, input int x,
                                 input int y, input logic [15:0] rgb, input logic we,
                                 input int waddr, input logic [8:0] wdata, input logic r);
        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC);
            $fatal(1, "[TB] history exhausted");
        end
        @(negedge clk);
        rst = r; in_de = de; in_hs = hs; in_vs = vs;
        in_x = 11'(x); in_y = 11'(y); in_rgb = rgb;
        txt_we = we; txt_waddr = 7'(waddr); txt_wdata = wdata;
        hDe[cyc] = de; hHs[cyc] = hs; hVs[cyc] = vs; hRgb[cyc] = rgb; hRst[cyc] = r;
        hInBox[cyc] = de && (x >= X0) && (x < X0 + 16 * NCOLS) && (y >= Y0) && (y < Y0 + 16 * NROWS);
        hCell[cyc] = hInBox[cyc] ? ((y - Y0) / 16) * NCOLS + (x - X0) / 16 : 0;
        hGx[cyc] = (x - X0) % 16;
        hGy[cyc] = (y - Y0) % 16;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 128; i++) textRef[i] = '0;
        end else if (we && waddr < NCOLS * NROWS) begin
            textRef[waddr] = wdata;
        end
        if (cyc >= 1) computeExpect(cyc - 1);
        if (r) mAddr = '0;
        else if (cyc >= 2 && hInBox[cyc - 2] && !rstWithin(cyc - 2, cyc)) mAddr = eAddr[cyc - 2];
        #1;
        checkOutput(cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0, 0, 0, 9'h0, 0);
    endtask

    task automatic writeCell(input int addr, input logic [8:0] code);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, addr, code, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) romMem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) romMem[i] = 16'h0000;
        for (int i = 0; i < 128; i++) textRef[i] = '0;

        tbl[0] = '{16,  16, 1'b1, 16'h1234, 1'b1, 13'h0410, 16'h8000, FG};
        tbl[1] = '{17,  16, 1'b1, 16'h2345, 1'b1, 13'h0410, 16'h8000, glyphZero(16'h2345)};
        tbl[2] = '{15,  16, 1'b1, 16'h3456, 1'b0, 13'h0000, 16'h0000, 16'h3456};
        tbl[3] = '{528, 16, 1'b1, 16'h4567, 1'b0, 13'h0000, 16'h0000, 16'h4567};
        tbl[4] = '{40,  37, 1'b1, 16'h5678, 1'b1, 13'h1AB5, 16'h0080, FG};
        tbl[5] = '{527, 79, 1'b1, 16'h6789, 1'b1, 13'h155F, 16'h0001, FG};
        tbl[6] = '{16,  80, 1'b1, 16'h789A, 1'b0, 13'h0000, 16'h0000, 16'h789A};
        tbl[7] = '{16,  16, 1'b0, 16'h89AB, 1'b0, 13'h0000, 16'h0000, 16'h0000};
        tbl[8] = '{30,  16, 1'b1, 16'h9ABC, 1'b1, 13'h0410, 16'h8000, glyphZero(16'h9ABC)};
        tbl[9] = '{47,  32, 1'b1, 16'hABCD, 1'b1, 13'h1AB0, 16'hFFFE, glyphZero(16'hABCD)};

        // Reset, then free-run with an empty text buffer.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 3, 9'h1FF, 1);
        for (int i = 0; i < 200; i++) begin
            applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                          $urandom_range(0, 600), $urandom_range(0, 100), 16'($urandom),
                          0, 0, 9'h0, 0);
        end

        // Random pixels, text writes and occasional reset pulses.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                          $urandom_range(0, 600), $urandom_range(0, 100), 16'($urandom),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 127), 9'($urandom),
                          $urandom_range(0, 99) == 0);
        end
        idle(6);

        writeCell(0, 9'h041);
        writeCell(33, 9'h1AB);
        writeCell(127, 9'h155);
        writeCell(5, 9'h0AA);

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].chkAddr) romMem[tbl[i].addr] = tbl[i].romWord;
            applyStimulus(tbl[i].de, 0, 0, tbl[i].x, tbl[i].y, tbl[i].rgb, 0, 0, 9'h0, 0);
            idle(2);
            if (tbl[i].chkAddr) compare($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(tbl[i].addr));
            idle(2);
            compare($sformatf("vec%0d_out_rgb", i), 32'(out_rgb), 32'(tbl[i].exp));
            compare($sformatf("vec%0d_out_de", i), 32'(out_de), 32'(tbl[i].de));
        end

        // Write to cell 5 in the cycle its code is read: the old code must reach rom_addr.
        applyStimulus(1, 0, 0, 96, 16, 16'h0F0F, 0, 0, 9'h0, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 0, 16'h0, 1, 5, 9'h133, 0);
        compare("collision_old_code", 32'(rom_addr), 32'(13'h0AA0));
        idle(2);
        applyStimulus(1, 0, 0, 96, 16, 16'h0F0F, 0, 0, 9'h0, 0);
        idle(2);
        compare("collision_new_code", 32'(rom_addr), 32'(13'h1330));
        idle(3);

        // One-clock reset in the middle of an active line of out-of-box pixels.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, i[0], 0, 100, 200, 16'h1000 + 16'(i), 0, 0, 9'h0, i == 3);
            if (i >= 3 && i <= 7) begin
                compare($sformatf("rst_flush_%0d", i), 32'({out_de, out_hs, out_vs, out_rgb}), 32'h0);
            end else if (i >= 8) begin
                compare($sformatf("rst_resume_rgb_%0d", i), 32'(out_rgb), 32'(16'h1000 + 16'(i - 4)));
                compare($sformatf("rst_resume_de_%0d", i), 32'(out_de), 32'h1);
            end
        end
        applyStimulus(1, 0, 0, 16, 23, 16'h5A5A, 0, 0, 9'h0, 0);
        idle(2);
        compare("txtbuf_cleared", 32'(rom_addr), 32'(13'h0007));
        idle(3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
